// File: rtl/async_fifo_wr_ctrl_if.sv
// Handshake and status bundle between an upstream word source, the async FIFO
// write port and the write-side controller.
interface async_fifo_wr_ctrl_if #(
    parameter int FIFO_WIDTH = 4
);
    logic                  s_valid;
    logic [FIFO_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;
    logic                  fifo_full;
    logic                  fifo_overflow;
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] wr_data;
    logic                  err_clr;
    logic [15:0]           pkt_count;
    logic                  in_pkt;
    logic                  err;
    logic                  stall_timeout;

    // Controller side
    modport slave (
        input  s_valid, s_data, s_last, fifo_full, fifo_overflow, err_clr,
        output s_ready, wr_en, wr_data, pkt_count, in_pkt, err, stall_timeout
    );

    // Upstream / FIFO / supervisor side
    modport master (
        output s_valid, s_data, s_last, fifo_full, fifo_overflow, err_clr,
        input  s_ready, wr_en, wr_data, pkt_count, in_pkt, err, stall_timeout
    );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller for an async FIFO: 2-entry skid buffer, packet FSM and error handling.
// Optional stall timeout is compiled in only when ASYNC_FIFO_WR_CTRL_TIMEOUT_EN is defined.
module async_fifo_wr_ctrl #(
    parameter int FIFO_WIDTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk_wr,
    input  logic               rst_n,
    async_fifo_wr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                state, state_nxt;
    logic [1:0]            cnt, cnt_nxt, wr_idx;
    logic [FIFO_WIDTH-1:0] data0, data1, data0_nxt, data1_nxt;
    logic                  last0, last1, last0_nxt, last1_nxt;
    logic [15:0]           pkt_cnt;
    logic                  s_ready_int, wr_en_int;
    logic                  push, pop, flush, timeout_hit;

    // Ready depends only on registered state so upstream sees no combinational loop
    assign s_ready_int = (cnt != 2'd2) && (state != ERR);
    assign wr_en_int   = (cnt != 2'd0) && !bus.fifo_full && (state != ERR);
    assign push        = bus.s_valid && s_ready_int;
    assign pop         = wr_en_int;
    assign flush       = (state_nxt == ERR);

    assign bus.s_ready   = s_ready_int;
    assign bus.wr_en     = wr_en_int;
    assign bus.wr_data   = data0;
    assign bus.pkt_count = pkt_cnt;
    assign bus.in_pkt    = (state == PKT);
    assign bus.err       = (state == ERR);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push && !bus.s_last) state_nxt = PKT;
            PKT:     if (push && bus.s_last)  state_nxt = IDLE;
            ERR:     if (bus.err_clr)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.fifo_overflow || timeout_hit) begin
            state_nxt = ERR;
        end
    end

    // Entry 0 is always the head; a push lands just behind whatever survives the pop
    always_comb begin
        data0_nxt = data0;
        data1_nxt = data1;
        last0_nxt = last0;
        last1_nxt = last1;
        wr_idx    = cnt - {1'b0, pop};
        if (pop) begin
            data0_nxt = data1;
            last0_nxt = last1;
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                data0_nxt = bus.s_data;
                last0_nxt = bus.s_last;
            end else begin
                data1_nxt = bus.s_data;
                last1_nxt = bus.s_last;
            end
        end
        cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            cnt_nxt = 2'd0;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            data0   <= '0;
            data1   <= '0;
            last0   <= 1'b0;
            last1   <= 1'b0;
            pkt_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            data0 <= data0_nxt;
            data1 <= data1_nxt;
            last0 <= last0_nxt;
            last1 <= last1_nxt;
            if (pop && last0) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

`ifdef ASYNC_FIFO_WR_CTRL_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       stall_flag;
    logic       stall_cond;

    assign stall_cond        = (cnt != 2'd0) && bus.fifo_full;
    assign timeout_hit       = stall_cond && (stall_cnt == TO_LAST);
    assign bus.stall_timeout = stall_flag;

    // Counts consecutive blocked cycles; any unblocked cycle restarts the count
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= 8'd0;
            stall_flag <= 1'b0;
        end else if (bus.err_clr) begin
            stall_cnt  <= 8'd0;
            stall_flag <= 1'b0;
        end else if (timeout_hit) begin
            stall_cnt  <= 8'd0;
            stall_flag <= 1'b1;
        end else if (stall_cond) begin
            stall_cnt  <= stall_cnt + 8'd1;
        end else begin
            stall_cnt  <= 8'd0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TO_LAST;
    assign timeout_hit        = 1'b0;
    assign bus.stall_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Scoreboard bench for async_fifo_wr_ctrl: stimulus queues expected writes, a monitor
// checks every wr_en cycle against the queue.
module tb_async_fifo_wr_ctrl;

    localparam int W  = 4;
    localparam int TO = 255;

    logic clk_wr = 1'b0;
    logic rst_n  = 1'b0;

    async_fifo_wr_ctrl_if #(.FIFO_WIDTH(W)) bus();

    async_fifo_wr_ctrl #(
        .FIFO_WIDTH (W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_wr(clk_wr),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_wr = ~clk_wr;

    int          total   = 0;
    int          bad     = 0;
    int          wr_seen = 0;
    int          wr_mark;
    logic [4:0]  exp_q[$];
    logic [4:0]  mon_e;
    logic [15:0] exp_pkt = 16'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] d, input logic l, input logic accept);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        if (accept) begin
            exp_q.push_back({l, d});
            if (l) exp_pkt++;
        end
        @(posedge clk_wr);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_wr);
            #1;
        end
    endtask

    // Monitor: every write must be expected, in order, and never while full
    always @(negedge clk_wr) begin
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            checkOutput("wr_en while full", {31'd0, bus.fifo_full}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected write: got data %0h expected no write", bus.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("wr_data", {28'd0, bus.wr_data}, {28'd0, mon_e[3:0]});
            end
        end
    end

    initial begin
        #1_000_000;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bus.s_valid       = 1'b0;
        bus.s_data        = '0;
        bus.s_last        = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_overflow = 1'b0;
        bus.err_clr       = 1'b0;

        // Reset values
        #12;
        checkOutput("rst s_ready", {31'd0, bus.s_ready}, 32'd1);
        checkOutput("rst wr_en", {31'd0, bus.wr_en}, 32'd0);
        checkOutput("rst wr_data", {28'd0, bus.wr_data}, 32'd0);
        checkOutput("rst in_pkt", {31'd0, bus.in_pkt}, 32'd0);
        checkOutput("rst err", {31'd0, bus.err}, 32'd0);
        checkOutput("rst pkt_count", {16'd0, bus.pkt_count}, 32'd0);
        checkOutput("rst stall_timeout", {31'd0, bus.stall_timeout}, 32'd0);
        @(negedge clk_wr);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] 8-word packet streaming");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(4'(i), (i == 8), 1'b1);
            checkOutput($sformatf("wr_en cycle %0d", i), {31'd0, bus.wr_en}, 32'd1);
            if (i == 1) checkOutput("in_pkt during packet", {31'd0, bus.in_pkt}, 32'd1);
        end
        tick(2);
        checkOutput("writes seen", wr_seen, 32'd8);
        checkOutput("queue drained 1", exp_q.size(), 32'd0);
        checkOutput("pkt_count 1", {16'd0, bus.pkt_count}, 32'd1);
        checkOutput("in_pkt after", {31'd0, bus.in_pkt}, 32'd0);
        checkOutput("wr_en idle", {31'd0, bus.wr_en}, 32'd0);

        $display("[TB] backpressure with fifo_full");
        bus.fifo_full = 1'b1;
        applyStimulus(4'hA, 1'b0, 1'b1);
        checkOutput("s_ready after 1", {31'd0, bus.s_ready}, 32'd1);
        checkOutput("wr_en full 1", {31'd0, bus.wr_en}, 32'd0);
        applyStimulus(4'hB, 1'b0, 1'b1);
        checkOutput("s_ready after 2", {31'd0, bus.s_ready}, 32'd0);
        checkOutput("wr_en full 2", {31'd0, bus.wr_en}, 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = 4'hC;
        bus.s_last  = 1'b1;
        tick(2);
        checkOutput("s_ready held off", {31'd0, bus.s_ready}, 32'd0);
        checkOutput("in_pkt stalled", {31'd0, bus.in_pkt}, 32'd1);
        bus.fifo_full = 1'b0;
        exp_q.push_back({1'b1, 4'hC});
        exp_pkt++;
        #1;
        checkOutput("wr_en on release", {31'd0, bus.wr_en}, 32'd1);
        tick(1);
        checkOutput("s_ready after pop", {31'd0, bus.s_ready}, 32'd1);
        tick(1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        tick(3);
        checkOutput("queue drained 2", exp_q.size(), 32'd0);
        checkOutput("pkt_count 2", {16'd0, bus.pkt_count}, {16'd0, exp_pkt});
        checkOutput("in_pkt after 2", {31'd0, bus.in_pkt}, 32'd0);

        $display("[TB] overflow mid-packet");
        bus.fifo_full = 1'b1;
        applyStimulus(4'hD, 1'b0, 1'b1);
        applyStimulus(4'hE, 1'b0, 1'b1);
        checkOutput("s_ready cnt2", {31'd0, bus.s_ready}, 32'd0);
        bus.fifo_overflow = 1'b1;
        tick(1);
        bus.fifo_overflow = 1'b0;
        exp_q.delete();
        checkOutput("err set", {31'd0, bus.err}, 32'd1);
        checkOutput("s_ready in err", {31'd0, bus.s_ready}, 32'd0);
        checkOutput("in_pkt in err", {31'd0, bus.in_pkt}, 32'd0);
        bus.fifo_full = 1'b0;
        #1;
        checkOutput("wr_en in err", {31'd0, bus.wr_en}, 32'd0);
        tick(2);
        checkOutput("err sticky", {31'd0, bus.err}, 32'd1);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        checkOutput("err cleared", {31'd0, bus.err}, 32'd0);
        checkOutput("s_ready after clr", {31'd0, bus.s_ready}, 32'd1);
        checkOutput("wr_en after flush", {31'd0, bus.wr_en}, 32'd0);
        checkOutput("pkt_count kept", {16'd0, bus.pkt_count}, {16'd0, exp_pkt});

        $display("[TB] reset mid-packet");
        bus.fifo_full = 1'b1;
        applyStimulus(4'h6, 1'b0, 1'b1);
        applyStimulus(4'h7, 1'b0, 1'b1);
        checkOutput("in_pkt before rst", {31'd0, bus.in_pkt}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid rst s_ready", {31'd0, bus.s_ready}, 32'd1);
        checkOutput("mid rst wr_en", {31'd0, bus.wr_en}, 32'd0);
        checkOutput("mid rst wr_data", {28'd0, bus.wr_data}, 32'd0);
        checkOutput("mid rst in_pkt", {31'd0, bus.in_pkt}, 32'd0);
        checkOutput("mid rst err", {31'd0, bus.err}, 32'd0);
        checkOutput("mid rst pkt_count", {16'd0, bus.pkt_count}, 32'd0);
        exp_q.delete();
        exp_pkt = 16'd0;
        bus.fifo_full = 1'b0;
        wr_mark = wr_seen;
        @(negedge clk_wr);
        rst_n = 1'b1;
        tick(4);
        checkOutput("no write after rst", wr_seen, wr_mark);
        checkOutput("wr_en after rst", {31'd0, bus.wr_en}, 32'd0);

        $display("[TB] pkt_count wrap");
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(4'(i), 1'b1, 1'b1);
        end
        tick(2);
        checkOutput("pkt_count ffff", {16'd0, bus.pkt_count}, 32'h0000_FFFF);
        applyStimulus(4'h5, 1'b1, 1'b1);
        tick(2);
        checkOutput("pkt_count wrap", {16'd0, bus.pkt_count}, 32'd0);
        checkOutput("queue drained 3", exp_q.size(), 32'd0);

        $display("[TB] stall timeout");
        bus.fifo_full = 1'b1;
        applyStimulus(4'h9, 1'b1, 1'b1);
        tick(TO - 1);
        checkOutput("stall before limit", {31'd0, bus.stall_timeout}, 32'd0);
        checkOutput("err before limit", {31'd0, bus.err}, 32'd0);
        tick(1);
`ifdef ASYNC_FIFO_WR_CTRL_TIMEOUT_EN
        checkOutput("stall at limit", {31'd0, bus.stall_timeout}, 32'd1);
        checkOutput("err at limit", {31'd0, bus.err}, 32'd1);
        checkOutput("s_ready at limit", {31'd0, bus.s_ready}, 32'd0);
        exp_q.delete();
        exp_pkt--;
        bus.fifo_full = 1'b0;
        bus.err_clr   = 1'b1;
        tick(1);
        bus.err_clr   = 1'b0;
        tick(2);
        checkOutput("stall cleared", {31'd0, bus.stall_timeout}, 32'd0);
        checkOutput("err cleared 2", {31'd0, bus.err}, 32'd0);
        checkOutput("s_ready cleared", {31'd0, bus.s_ready}, 32'd1);
`else
        checkOutput("stall disabled", {31'd0, bus.stall_timeout}, 32'd0);
        checkOutput("no err without timeout", {31'd0, bus.err}, 32'd0);
        bus.fifo_full = 1'b0;
        tick(3);
`endif
        checkOutput("pkt_count end", {16'd0, bus.pkt_count}, {16'd0, exp_pkt});
        checkOutput("queue drained 4", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_ctrl.md
ASYNC_FIFO_WR_CTRL -- requirements
Module: async_fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 4, word width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, stall-timeout threshold in clk_wr cycles (8-bit).
REQ-003 SHALL have port clk_wr  input  1  write-domain clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  upstream word valid.
REQ-006 SHALL have port s_data  input  FIFO_WIDTH  upstream word.
REQ-007 SHALL have port s_last  input  1  upstream word ends a packet.
REQ-008 SHALL have port s_ready  output  1  controller can accept a word.
REQ-009 SHALL have port fifo_full  input  1  async FIFO full flag.
REQ-010 SHALL have port fifo_overflow  input  1  async FIFO overflow flag.
REQ-011 SHALL have port wr_en  output  1  FIFO write enable.
REQ-012 SHALL have port wr_data  output  FIFO_WIDTH  FIFO write data.
REQ-013 SHALL have port err_clr  input  1  single-cycle pulse clearing ERR state.
REQ-014 SHALL have port pkt_count  output  16  packets fully written into the FIFO.
REQ-015 SHALL have port in_pkt  output  1  high while state is PKT.
REQ-016 SHALL have port err  output  1  high while state is ERR.
REQ-017 SHALL have port stall_timeout  output  1  sticky stall-timeout flag.

Function
REQ-018 SHALL hold a 2-entry skid buffer (data + last bit), occupancy cnt 0..2, FIFO order.
REQ-019 SHALL drive s_ready = (cnt != 2) && !err, decoded from registers only; no path from s_valid or fifo_full.
REQ-020 SHALL accept (push) a word when s_valid && s_ready.
REQ-021 SHALL drive wr_en = (cnt != 0) && !fifo_full && !err, combinationally; wr_data = head entry data.
REQ-022 SHALL pop the head entry whenever wr_en is high; push and pop in the same cycle leave cnt unchanged and preserve order.
REQ-023 SHALL implement states IDLE, PKT, ERR: IDLE->PKT on push with s_last=0; PKT->IDLE on push with s_last=1; push with s_last=1 in IDLE stays IDLE (single-word packet).
REQ-024 SHALL enter ERR from any state the cycle after fifo_overflow is sampled high; ERR has priority over all other transitions.
REQ-025 SHALL in ERR flush the skid buffer (cnt=0), force s_ready=0, wr_en=0, and exit to IDLE on the edge sampling err_clr=1.
REQ-026 SHALL increment pkt_count by 1 on each pop whose entry has last=1, wrapping 16'hFFFF->0.
REQ-027 SHALL never assert wr_en while fifo_full is high (overflow-free by construction when FIFO flags are correct).
REQ-028 SHALL give one-cycle latency from accepted word (cnt=0, not full) to wr_en high.
REQ-029 SHALL sustain one word per cycle when fifo_full stays low.

Reset
REQ-030 SHALL on rst_n low asynchronously set state=IDLE, cnt=0, pkt_count=0, stall counter=0, stall_timeout=0, skid contents=0.
REQ-031 SHALL consequently present s_ready=1, wr_en=0, wr_data=0, in_pkt=0, err=0 during reset.
REQ-032 SHALL on reset mid-packet discard the partial packet without writing any further word.

Configuration
REQ-033 SHALL compile the stall timeout only when macro ASYNC_FIFO_WR_CTRL_TIMEOUT_EN is defined.
REQ-034 SHALL with the macro defined count consecutive cycles with cnt!=0 && fifo_full, clear the count on any other cycle, and on reaching TIMEOUT_CYC set stall_timeout and enter ERR; err_clr clears stall_timeout and the count.
REQ-035 SHALL without the macro tie stall_timeout to 0 and omit the counter.

Verification
REQ-036 SHALL cover: reset, then 8 words 0x1..0x8 with s_last on 0x8, fifo_full=0 -> wr_en high 8 consecutive cycles from cycle 1, data 0x1..0x8 in order, pkt_count=1, in_pkt low afterwards.
REQ-037 SHALL cover: fifo_full=1 held, 3 words offered -> 2 accepted, s_ready=0 after second, wr_en=0; release full -> words written in order, third then accepted.
REQ-038 SHALL cover: fifo_overflow pulse mid-packet with cnt=2 -> err=1 next cycle, cnt=0, s_ready=0; err_clr pulse -> IDLE, s_ready=1, pkt_count unchanged.
REQ-039 SHALL cover: pkt_count preset path via 65536 single-word packets -> pkt_count wraps to 0.
REQ-040 SHALL cover: with ASYNC_FIFO_WR_CTRL_TIMEOUT_EN, fifo_full held 255 cycles with cnt=1 -> stall_timeout=1 and err=1 at cycle 255; without macro -> stall_timeout stays 0, no ERR.
REQ-041 SHALL cover: rst_n asserted mid-packet with cnt=2 -> all outputs at reset values immediately, no wr_en after release until new input.
